bram_lsu: RTL
=============

BRAM_LSU -- requirements
Module: bram_lsu

Interface
REQ-001 SHALL have one clock, CLK; reset is RSTN, asynchronous, active-low.
REQ-002 Ports (name  direction  width  meaning):
- CLK  in  1  clock, rising edge.
- RSTN  in  1  async active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  unit idle, accepts a command.
- cmd_op  in  1  0 = load (BRAM to vector), 1 = store (vector to BRAM).
- cmd_base  in  32  start word address.
- cmd_len  in  5  word count; legal range 1..16.
- vec_in  in  512  store data; word i is bits [32i+31:32i].
- vec_out  out  512  load result, same packing as vec_in.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; command was rejected.
- busy  out  1  state is not IDLE.
- addrb  out  32  BRAM word address.
- dinb  out  32  BRAM write data.
- doutb  in  32  BRAM read data; combinational from addrb when enb = 1.
- enb  out  1  BRAM enable.
- web  out  4  BRAM write code.
REQ-003 Parameter DEPTH, default 48, is the BRAM size in words.

Function
REQ-004 SHALL implement the FSM states IDLE, LOAD, STORE and DONE.
REQ-005 cmd_ready SHALL be 1 only in IDLE; a command is accepted at a rising edge where cmd_valid = 1 and cmd_ready = 1.
REQ-006 On accept, cmd_base, cmd_len and cmd_op SHALL be registered; for a store, vec_in SHALL be copied into an internal buffer, so later changes to vec_in have no effect.
REQ-007 Illegal command: cmd_len = 0, cmd_len > 16, or cmd_base + cmd_len > DEPTH, with the sum computed at 33 bits (no wrap).
- FSM goes IDLE to DONE directly.
- No BRAM access is made.
- err = 1 together with done.
- vec_out is unchanged.
REQ-008 Legal load: on accept, vec_out SHALL be cleared to 0 and the FSM SHALL enter LOAD.
REQ-009 Legal store: on accept, the FSM SHALL enter STORE.
REQ-010 Beat counter idx starts at 0 and increments by 1 per beat.
- Each LOAD/STORE cycle is one beat.
- The beat with idx = len-1 is the last beat; the state after it is DONE.
REQ-011 LOAD beat:
- addrb = base + idx, enb = 1, web = 4'b0000.
- doutb is captured into vec_out word idx at the closing rising edge.
REQ-012 STORE beat:
- addrb = base + idx, dinb = buffer word idx, enb = 1, web = 4'b0111 (the BRAM port write code).
- The BRAM commits the word at the closing rising edge.
REQ-013 Outside LOAD/STORE beats: addrb = 0, dinb = 0, enb = 0, web = 4'b0000.
REQ-014 DONE SHALL last exactly one cycle with done = 1, then return to IDLE.
- err = 0 in DONE unless the command was illegal (REQ-007).
- err = 0 in all other states.
REQ-015 Latency for a legal N-word command accepted at edge E0:
- Beats occupy cycles 1..N after E0.
- done is high in cycle N+1.
- cmd_ready returns in cycle N+2.
REQ-016 Back-to-back: with cmd_valid held high, the next command SHALL be accepted at the first edge where the FSM is in IDLE, i.e. no earlier than the edge after DONE.
REQ-017 vec_out words with index >= len SHALL read 0 after a load; vec_out SHALL hold its value until the next legal load is accepted.
REQ-018 busy SHALL equal (state != IDLE).
REQ-019 All outputs SHALL be driven from registers or from decoded state/idx only; no combinational path from any input to any output.

Reset
REQ-020 RSTN low SHALL immediately, without waiting for a clock edge:
- force state to IDLE;
- clear idx, the store buffer and vec_out;
- drive enb = 0, web = 0, addrb = 0, dinb = 0, done = 0, err = 0, busy = 0;
- drive cmd_ready = 1.
REQ-021 A reset during LOAD/STORE SHALL abort the command: words already committed remain in BRAM, no done pulse is produced, and the first command after RSTN rises is accepted normally.

Verification
REQ-022 BRAM preloaded with words 0..15 = 15,20,42,65,98,56,24,78,91,97,33,62,57,23,19,7; load base 0, len 16 -> vec_out word0 = 15, word15 = 7; done exactly 17 cycles after accept; err = 0.
REQ-023 Load base 16, len 4, with words 16..19 = 48,35,33,49 -> vec_out words 0..3 = 48,35,33,49, words 4..15 = 0; enb high exactly 4 cycles.
REQ-024 Store base 32, len 16, vec_in word i = 3*i, vec_in changed after accept -> web = 4'b0111 on 16 consecutive cycles with addrb 32..47; read-back load returns 0,3,...,45.
REQ-025 Load base 40, len 16 (exceeds DEPTH) -> done = 1 and err = 1 in the cycle after accept, enb never high, vec_out unchanged; len 0 gives the same result.
REQ-026 RSTN asserted mid-clock after 5 store beats at base 32 -> enb and web drop to 0 without a clock edge; BRAM words 32..36 updated, 37..47 unchanged; no done pulse.
REQ-027 Two loads issued back-to-back with cmd_valid held -> second accepted at the edge after the first DONE; both done pulses one cycle wide.

Source files
------------

// File: rtl/bram_lsu.sv
// bram_lsu: moves 1..16 words between a single-port BRAM and a 512-bit vector.
// Ports: CLK/RSTN; cmd_valid/cmd_ready/cmd_op/cmd_base/cmd_len command;
//   vec_in/vec_out vector data; done/err/busy status; addrb/dinb/doutb/enb/web BRAM port.
module bram_lsu #(
    parameter int unsigned DEPTH = 48
) (
    input  logic         CLK,
    input  logic         RSTN,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic         cmd_op,
    input  logic [31:0]  cmd_base,
    input  logic [4:0]   cmd_len,
    input  logic [511:0] vec_in,
    output logic [511:0] vec_out,
    output logic         done,
    output logic         err,
    output logic         busy,
    output logic [31:0]  addrb,
    output logic [31:0]  dinb,
    input  logic [31:0]  doutb,
    output logic         enb,
    output logic [3:0]   web
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STORE,
        DONE
    } state_t;

    state_t       state;
    logic [31:0]  base;
    logic [4:0]   len;
    logic         op;
    logic [3:0]   idx;
    logic [511:0] sbuf;

    logic [32:0]  end_addr;
    logic         illegal;
    logic         last;
    logic         beat;

    // End address is formed at 33 bits so a base near 2^32 cannot wrap
    // into a range that looks legal.
    assign end_addr = {1'b0, cmd_base} + {28'd0, cmd_len};
    assign illegal  = (cmd_len == 5'd0) || (cmd_len > 5'd16)
                   || (end_addr > 33'(DEPTH));
    assign last     = ({1'b0, idx} == (len - 5'd1));
    assign beat     = (state == LOAD) || (state == STORE);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state   <= IDLE;
            base    <= '0;
            len     <= '0;
            op      <= 1'b0;
            idx     <= '0;
            sbuf    <= '0;
            vec_out <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        base <= cmd_base;
                        len  <= cmd_len;
                        op   <= cmd_op;
                        idx  <= '0;
                        if (illegal) begin
                            state <= DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else if (cmd_op) begin
                            sbuf  <= vec_in;
                            state <= STORE;
                        end else begin
                            vec_out <= '0;
                            state   <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    vec_out[{idx, 5'd0} +: 32] <= doutb;
                    idx <= idx + 4'd1;
                    if (last) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                STORE: begin
                    idx <= idx + 4'd1;
                    if (last) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // BRAM port is decoded from registered state/idx only, so an async
    // reset drops enb/web at once.
    always_comb begin
        addrb = '0;
        dinb  = '0;
        enb   = 1'b0;
        web   = 4'b0000;
        if (beat) begin
            addrb = base + {28'd0, idx};
            enb   = 1'b1;
            if (state == STORE && op) begin
                dinb = sbuf[{idx, 5'd0} +: 32];
                web  = 4'b0111;
            end
        end
    end

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

endmodule
